// File: rtl/sort_engine_if.sv
// Valid/ready stream bundle for sort_engine: the input word stream, the sorted
// output stream and the busy status flag.
interface sort_engine_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          desc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  modport master (
    output in_valid, in_data, in_last, desc, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, desc, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/sort_engine.sv
// Frame sorter: loads up to DEPTH words, sorts them in place with a stable
// odd-even transposition network, then streams them out with arrival indices.
module sort_engine #(
  parameter int  DW    = 8,
  parameter int  DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  sort_engine_if.slave bus
);
  // Counts must reach DEPTH itself, so they carry one extra bit.
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, n_q, pass_q;
  logic [AW-1:0] rd_ptr_q;
  logic          desc_q;

  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [AW-1:0] tag_q  [DEPTH];
  logic [AW-1:0] tag_d  [DEPTH];

  logic in_ready, out_valid, in_fire, out_fire, frame_end, last_word, sorting;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;
  assign frame_end = in_fire && (bus.in_last || count_q == CW'(DEPTH - 1));
  assign last_word = ({1'b0, rd_ptr_q} == n_q - CW'(1));
  // The cycle after the n-th pass only hands over to DRAIN.
  assign sorting   = (state_q == S_SORT) && (pass_q != n_q);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: always_comb assigns every output a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_fire)                state_d = frame_end ? S_SORT : S_LOAD;
      S_LOAD:  if (frame_end)              state_d = S_SORT;
      S_SORT:  if (pass_q == n_q)          state_d = S_DRAIN;
      S_DRAIN: if (out_fire && last_word)  state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      n_q      <= '0;
      pass_q   <= '0;
      rd_ptr_q <= '0;
      desc_q   <= 1'b0;
    end else begin
      if (in_fire) begin
        if (state_q == S_IDLE) desc_q <= bus.desc;
        if (frame_end) begin
          count_q <= '0;
          n_q     <= count_q + CW'(1);
        end else begin
          count_q <= count_q + CW'(1);
        end
      end
      pass_q <= (state_q == S_SORT) ? pass_q + CW'(1) : '0;
      if (state_q == S_SORT)  rd_ptr_q <= '0;
      else if (out_fire)      rd_ptr_q <= last_word ? '0 : rd_ptr_q + AW'(1);
    end
  end

  // Even passes pair (0,1),(2,3)..; odd passes pair (1,2),(3,4)..; pairs are
  // disjoint, so all swaps of a pass resolve in parallel.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if ((i % 2) == int'(pass_q[0]) && (i + 1) < int'(n_q)) begin
        if (desc_q ? (data_q[i] < data_q[i+1]) : (data_q[i] > data_q[i+1])) begin
          data_d[i]   = data_q[i+1];
          data_d[i+1] = data_q[i];
          tag_d[i]    = tag_q[i+1];
          tag_d[i+1]  = tag_q[i];
        end
      end
    end
  end

  // NOTE: the word array has no reset; a frame always overwrites the entries
  // it uses before they are read, so reset muxes here would buy nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (in_fire && count_q == CW'(i)) begin
        data_q[i] <= bus.in_data;
        tag_q[i]  <= AW'(i);
      end else if (sorting) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? data_q[rd_ptr_q] : '0;
  assign bus.out_idx   = out_valid ? tag_q[rd_ptr_q]  : '0;
  assign bus.out_last  = out_valid && last_word;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: random and directed frames compared
// against a stable insertion-sort model, with backpressure and reset cases.
module tb_sort_engine;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sort_engine_if #(.DW(DW), .AW(AW)) bus ();

  sort_engine #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int w_data[$];
  bit w_last[$];
  bit w_desc[$];
  int acc_cyc[64];
  int exp_d[DEPTH];
  int exp_i[DEPTH];
  bit rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_words();
    w_data.delete();
    w_last.delete();
    w_desc.delete();
    for (int i = 0; i < 64; i++) acc_cyc[i] = -1;
  endtask

  task automatic set_frame(input int vals[$], input bit d, input bit toggle, input bit use_last);
    clear_words();
    for (int i = 0; i < vals.size(); i++) begin
      w_data.push_back(vals[i]);
      w_last.push_back(use_last && (i == vals.size() - 1));
      w_desc.push_back((toggle && i > 0) ? ~d : d);
    end
  endtask

  // Reference: stable insertion sort on the frame, direction from its first word.
  task automatic build_model(input int start, input int n);
    bit d;
    d = w_desc[start];
    for (int i = 0; i < n; i++) begin
      exp_d[i] = w_data[start + i];
      exp_i[i] = i;
    end
    for (int i = 1; i < n; i++) begin
      int kd = exp_d[i];
      int ki = exp_i[i];
      int j  = i;
      while (j > 0 && (d ? (exp_d[j-1] < kd) : (exp_d[j-1] > kd))) begin
        exp_d[j] = exp_d[j-1];
        exp_i[j] = exp_i[j-1];
        j--;
      end
      exp_d[j] = kd;
      exp_i[j] = ki;
    end
  endtask

  task automatic send_all();
    for (int i = 0; i < w_data.size(); i++) begin
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(w_data[i]);
      bus.in_last  = w_last[i];
      bus.desc     = w_desc[i];
      while (!bus.in_ready && waited < 500) begin
        @(posedge clk); #1;
        waited++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 32'd1);
      if (!bus.in_ready) begin
        bus.in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      acc_cyc[i]   = cyc;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.desc     = $urandom_range(0, 1) != 0;
    end
  endtask

  // mode 0: always ready, 1: fixed 1,0,0,1,0,1 pattern, 2: random ready.
  task automatic drain(input int start, input int n, input int close, input int mode);
    int j = 0;
    int first = -1;
    int pat = 0;
    bit held = 1'b0;
    bit ctl_bad = 1'b0;
    bit zero_bad = 1'b0;
    logic [DW-1:0] hd;
    logic [AW-1:0] hi;
    logic          hl;
    build_model(start, n);
    for (int c = 0; c < 600 && j < n; c++) begin
      if (bus.out_valid) begin
        if (first < 0) begin
          first = cyc;
          check("latency", 32'(first - acc_cyc[close]), 32'(n + 1));
        end
        if (held) begin
          check("hold_data", 32'(bus.out_data), 32'(hd));
          check("hold_idx",  32'(bus.out_idx),  32'(hi));
          check("hold_last", 32'(bus.out_last), 32'(hl));
        end
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) ctl_bad = 1'b1;
        case (mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = rdy_pat[pat % 6];
          default: bus.out_ready = $urandom_range(0, 1) != 0;
        endcase
        pat++;
        if (bus.out_ready) begin
          check("out_data", 32'(bus.out_data), 32'(exp_d[j]));
          check("out_idx",  32'(bus.out_idx),  32'(exp_i[j]));
          check("out_last", 32'(bus.out_last), 32'(j == n - 1));
          j++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = bus.out_data;
          hi   = bus.out_idx;
          hl   = bus.out_last;
        end
      end else begin
        if (bus.out_data !== '0 || bus.out_idx !== '0 || bus.out_last !== 1'b0) zero_bad = 1'b1;
        if (acc_cyc[close] >= 0 && cyc > acc_cyc[close] &&
            (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)) ctl_bad = 1'b1;
        bus.out_ready = $urandom_range(0, 1) != 0;
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    check("drain_count",    32'(j),        32'(n));
    check("busy_ctl",       32'(ctl_bad),  32'd0);
    check("zero_not_valid", 32'(zero_bad), 32'd0);
    check("end_valid",      32'(bus.out_valid), 32'd0);
    check("end_busy",       32'(bus.busy),      32'd0);
    check("end_in_ready",   32'(bus.in_ready),  32'd1);
    check("end_data",       32'(bus.out_data),  32'd0);
  endtask

  task automatic run_frame(input int mode);
    fork
      send_all();
      drain(0, w_data.size(), w_data.size() - 1, mode);
    join
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},    32'(bus.out_valid), 32'd0);
    check({tag, "_busy"},     32'(bus.busy),      32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready),  32'd1);
    check({tag, "_data"},     32'(bus.out_data),  32'd0);
    check({tag, "_idx"},      32'(bus.out_idx),   32'd0);
    check({tag, "_last"},     32'(bus.out_last),  32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[$];
    int waited;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.desc      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Directed ascending frame of eight words
    v = {5, 3, 8, 1, 9, 2, 7, 4};
    set_frame(v, 1'b0, 1'b0, 1'b1);
    run_frame(0);

    // Descending, with desc toggled after the first word
    v = {10, 30, 20};
    set_frame(v, 1'b1, 1'b1, 1'b1);
    run_frame(0);

    // Stability with duplicate keys, both directions
    v = {4, 2, 4, 2};
    set_frame(v, 1'b0, 1'b0, 1'b1);
    run_frame(2);
    set_frame(v, 1'b1, 1'b0, 1'b1);
    run_frame(2);

    // Backpressure pattern on a random full frame
    v.delete();
    for (int i = 0; i < DEPTH; i++) v.push_back(int'($urandom_range(0, 255)));
    set_frame(v, 1'b0, 1'b0, 1'b1);
    run_frame(1);

    // Single word frame
    v = {170};
    set_frame(v, 1'b0, 1'b0, 1'b1);
    run_frame(0);

    // Overflow: 8 words close on depth; words 9-10 wait and form the next frame
    clear_words();
    for (int i = 0; i < 10; i++) begin
      w_data.push_back(int'($urandom_range(0, 31)));
      w_last.push_back(i == 9);
      w_desc.push_back(i >= 8);
    end
    fork
      send_all();
      begin
        drain(0, DEPTH, DEPTH - 1, 2);
        drain(DEPTH, 2, 9, 2);
      end
    join

    // Random frames
    for (int f = 0; f < 12; f++) begin
      int sz = int'($urandom_range(1, DEPTH));
      int maxv = (f % 2 == 0) ? 7 : 255;
      v.delete();
      for (int i = 0; i < sz; i++) v.push_back(int'($urandom_range(0, maxv)));
      set_frame(v, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                (sz != DEPTH) || ($urandom_range(0, 1) != 0));
      run_frame(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of SORT
    v = {9, 8, 7, 6, 5, 4, 3, 2};
    set_frame(v, 1'b0, 1'b0, 1'b1);
    send_all();
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_sort_busy", 32'(bus.busy), 32'd1);
    pulse_reset();
    check_idle("rst_sort");
    v = {7, 6};
    set_frame(v, 1'b0, 1'b0, 1'b1);
    run_frame(0);

    // Reset in the middle of DRAIN
    v = {3, 1, 2};
    set_frame(v, 1'b0, 1'b0, 1'b1);
    send_all();
    bus.out_ready = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("pre_rst_drain_valid", 32'(bus.out_valid), 32'd1);
    pulse_reset();
    check_idle("rst_drain");
    v = {7, 6};
    set_frame(v, 1'b0, 1'b0, 1'b1);
    run_frame(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
